// File: rtl/store_pkg.sv
// Shared encodings for the sub-word store path: store-op codes, FSM states and the alignment check.
package store_pkg;

    localparam logic [1:0] SOP_SW  = 2'b00;
    localparam logic [1:0] SOP_SH  = 2'b01;
    localparam logic [1:0] SOP_SB  = 2'b10;
    localparam logic [1:0] SOP_RSV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_ERR
    } state_e;

    // True when the store's low address bits do not match its natural alignment.
    function automatic logic misaligned(input logic [1:0] sop, input logic [1:0] addr_lo);
        return ((sop == SOP_SH) && addr_lo[0]) || ((sop == SOP_SW) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/sub_word_store_lane_merge.sv
// Byte-lane merge: replaces the lanes selected by the store op and address in the old memory word.
module lane_merge
    import store_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  sop_i,
    output logic [31:0] merged_o
);

    logic [3:0] be;

    always_comb begin
        be = 4'b0000;
        case (sop_i)
            SOP_SW:  be = 4'b1111;
            SOP_SH:  be = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            SOP_SB:  be = 4'b0001 << addr_lo_i;
            default: be = 4'b0000;
        endcase
    end

    // Each lane picks the data byte that lands on it: SB replicates byte 0, SH repeats the half.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] src;
            assign src = (sop_i == SOP_SB) ? data_i[7:0] :
                         (sop_i == SOP_SH) ? data_i[8*(gi%2) +: 8] :
                                             data_i[8*gi +: 8];
            assign merged_o[8*gi +: 8] = be[gi] ? src : old_word_i[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/sub_word_store.sv
// Sub-word store unit: SW/SH/SB into a word-only memory via read-modify-write, one request at a time.
// Optional build macro MISALIGN_TRAP_EN turns misaligned SH/SW into an error completion.
module sub_word_store
    import store_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        SOp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        sop_q, sop_d;
    logic [31:0]       merged;
    logic              accept;
    logic              trap;

    lane_merge u_lane_merge (
        .old_word_i (mem_rdata),
        .data_i     (wdata_q),
        .addr_lo_i  (addr_q[1:0]),
        .sop_i      (sop_q),
        .merged_o   (merged)
    );

`ifdef MISALIGN_TRAP_EN
    assign trap = misaligned(SOp, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sop_d   = sop_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    sop_d   = SOp;
                    if ((SOp == SOP_RSV) || trap) begin
                        state_d = ST_ERR;
                    end else if (SOp == SOP_SW) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: begin
                // Merged word replaces the raw data so WR drives it straight out.
                wdata_d = merged;
                state_d = ST_WR;
            end
            ST_WR:   state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            sop_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sop_q   <= sop_d;
        end
    end

    // Every output is forced low while reset is held, even before the reset edge.
    assign req_ready = reset && (state_q == ST_IDLE);
    assign mem_rd_en = reset && (state_q == ST_RD);
    assign mem_wr_en = reset && (state_q == ST_WR);
    assign done      = mem_wr_en;
    assign err       = reset && (state_q == ST_ERR);
    assign mem_addr  = reset ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = reset ? wdata_q : '0;

endmodule

// File: tb/tb_sub_word_store.sv
// Scoreboard bench for sub_word_store: directed cases, randomized stores, reset abort.
module tb_sub_word_store;
    import store_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  SOp = '0;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata = '0;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;

    sub_word_store #(.ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .SOp       (SOp),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        int          reads;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          fails = 0;
    int          cycle = 0;
    int          reads_seen = 0;
    bit          ready_expect = 0;
    exp_t        e_m;
    logic [31:0] env_mem[16];
    logic [31:0] ref_mem[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference: word-granular memory, lanes replaced with shifts and masks.
    function automatic exp_t model(input logic [1:0] sop, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int          w;
        int          sh;
        logic [31:0] old;
        bit          trap;
        w = int'(a[5:2]);
        old = ref_mem[w];
        trap = 0;
`ifdef MISALIGN_TRAP_EN
        trap = ((sop == 2'd1) && a[0]) || ((sop == 2'd0) && (a[1:0] != 2'd0));
`endif
        e.addr = a & 32'hFFFF_FFFC;
        e.is_err = (sop == 2'd3) || trap;
        e.data = '0;
        e.lat = 1;
        e.reads = 0;
        e.acc = 0;
        if (!e.is_err) begin
            case (sop)
                2'd0: e.data = d;
                2'd1: begin
                    sh = a[1] ? 16 : 0;
                    e.data = (old & ~(32'h0000FFFF << sh)) | ((d & 32'h0000FFFF) << sh);
                end
                default: begin
                    sh = 8 * int'(a[1:0]);
                    e.data = (old & ~(32'h000000FF << sh)) | ((d & 32'h000000FF) << sh);
                end
            endcase
            if (sop != 2'd0) begin
                e.lat = 3;
                e.reads = 1;
            end
            ref_mem[w] = e.data;
        end
        return e;
    endfunction

    always @(posedge clk) cycle <= cycle + 1;

    // Memory environment: read data valid the cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (mem_wr_en) env_mem[mem_addr[5:2]] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= env_mem[mem_addr[5:2]];
        else           mem_rdata <= $urandom;
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_outputs_zero", {25'd0, req_ready, mem_rd_en, mem_wr_en, done, err,
                (mem_addr != 32'd0), (mem_wdata != 32'd0)}, 32'd0);
            reads_seen = 0;
            ready_expect = 0;
        end else begin
            if (ready_expect) chk("ready_after_completion", {31'd0, req_ready}, 32'd1);
            ready_expect = 0;
            if (mem_rd_en || mem_wr_en || err || done) begin
                chk("strobe_one_hot", {31'd0, (32'(mem_rd_en) + 32'(mem_wr_en) + 32'(err)) <= 1}, 32'd1);
                chk("done_eq_wr", {31'd0, done}, {31'd0, mem_wr_en});
            end
            if (mem_rd_en) reads_seen++;
            if (mem_wr_en || err) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_completion: wr=%b err=%b addr=%h, required no completion",
                             mem_wr_en, err, mem_addr);
                end else begin
                    e_m = sb_q.pop_front();
                    chk("kind_err", {31'd0, err}, {31'd0, e_m.is_err});
                    if (!e_m.is_err) begin
                        chk("mem_addr", mem_addr, e_m.addr);
                        chk("mem_wdata", mem_wdata, e_m.data);
                    end
                    chk("latency", 32'(cycle - e_m.acc + 1), 32'(e_m.lat));
                    chk("read_count", 32'(reads_seen), 32'(e_m.reads));
                end
                reads_seen = 0;
                ready_expect = 1;
            end
        end
    end

    // Called at posedge+1; leaves req_valid high so a follow-on request can queue behind a busy DUT.
    task automatic issue(input logic [1:0] sop, input logic [31:0] a, input logic [31:0] d, input bit push);
        int   n;
        exp_t e;
        req_valid = 1'b1;
        SOp = sop;
        req_addr = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: req_ready low for %0d cycles, required high", n);
        end
        @(posedge clk);
        #1;
        if (push) begin
            e = model(sop, a, d);
            e.acc = cycle;
            sb_q.push_back(e);
        end
    endtask

    task automatic gap(input int k);
        req_valid = 1'b0;
        SOp = 2'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = 1'b0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: %0d completions pending, required 0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        env_mem[4] = 32'h11223344; ref_mem[4] = 32'h11223344;
        env_mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
        env_mem[9] = 32'h11223344; ref_mem[9] = 32'h11223344;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

        issue(SOP_SB, 32'h13, 32'h123456AA, 1);
        issue(SOP_SW, 32'h10, 32'hDEADBEEF, 1);
        issue(SOP_SH, 32'h22, 32'h0000BEEF, 1);
        issue(SOP_RSV, 32'h30, 32'h5555AAAA, 1);
        issue(SOP_SH, 32'h25, 32'h0000BEEF, 1);
        drain();
        chk("mem_word_0x10", env_mem[4], 32'hDEADBEEF);
        chk("mem_word_0x20", env_mem[8], 32'hBEEF3344);
`ifdef MISALIGN_TRAP_EN
        chk("mem_word_0x24", env_mem[9], 32'h11223344);
`else
        chk("mem_word_0x24", env_mem[9], 32'h1122BEEF);
`endif

        for (int i = 0; i < 300; i++) begin
            issue(2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)), $urandom, 1);
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
        end
        drain();

        // Abort an SB in WAIT: no write, no done, then a clean SW.
        issue(SOP_SB, 32'h13, 32'h000000AA, 0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_outputs_zero", {28'd0, req_ready, mem_rd_en, mem_wr_en, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("ready_after_abort", {31'd0, req_ready}, 32'd1);
        issue(SOP_SW, 32'h08, 32'hCAFEF00D, 1);
        drain();
        chk("mem_word_0x08", env_mem[2], 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule
